pcm_granule_reader: RTL and testbench

- Consumer side of the decoding_chain PCM output buffer.
- When pcm_ready is high, reads one granule of 576 stereo samples through the synchronous-read port (pcm_read_addr, pcm_read_data_ch0/ch1).
- Streams the samples downstream over a valid/ready interface toward the audio output path, then releases the buffer with a one-cycle pcm_done pulse.
- Optionally discards the first SKIP_GRANULES granules (pipeline warm-up).

---
 rtl/pcm_granule_reader_pkg.sv | 7 +
 rtl/pcm_skid_fifo.sv | 39 +++
 rtl/pcm_granule_reader.sv | 95 +++++++++
 tb/tb_pcm_granule_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_granule_reader_pkg.sv
// pcm_granule_reader_pkg: shared PCM constants and reader FSM states
// Holds the granule size, the default PCM sample width and the state encoding.
package pcm_granule_reader_pkg;
    localparam int PCM_GRANULE_SAMPLES = 576;
    localparam int PCM_DATA_WIDTH = 18;
    typedef enum logic [2:0] {ST_SKIP, ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE, ST_GUARD} state_t;
endpackage

// File: rtl/pcm_skid_fifo.sv
// pcm_skid_fifo: 2-entry FIFO with count/empty, async active-high reset
// Ports: clk, rst, push/din write, pop reads the head, dout is the head entry,
// count is 0..2, empty is count==0. The caller never pushes when full or pops when empty.
module pcm_skid_fifo
    import pcm_granule_reader_pkg::*;
#(
    parameter int WIDTH = 2 * PCM_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic rd_ptr, wr_ptr;

    assign dout = mem[rd_ptr];
    assign empty = count == 2'd0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/pcm_granule_reader.sv
// pcm_granule_reader: reads one PCM granule and streams it downstream
// Ports: pcm_ready/pcm_done buffer handshake; pcm_read_addr with sync-read data
// pcm_read_data_ch0/ch1; sample_valid/sample_ready stream of sample_ch0/ch1/sample_last;
// granule_count counts streamed (not skipped) granules.
module pcm_granule_reader
    import pcm_granule_reader_pkg::*;
#(
    parameter int GRANULE_SAMPLES = PCM_GRANULE_SAMPLES,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = PCM_DATA_WIDTH,
    parameter int SKIP_GRANULES = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcm_ready,
    output logic                   pcm_done,
    output logic [ADDR_WIDTH-1:0]  pcm_read_addr,
    input  logic [DATA_WIDTH-1:0]  pcm_read_data_ch0,
    input  logic [DATA_WIDTH-1:0]  pcm_read_data_ch1,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic [DATA_WIDTH-1:0]  sample_ch0,
    output logic [DATA_WIDTH-1:0]  sample_ch1,
    output logic                   sample_last,
    output logic [COUNT_WIDTH-1:0] granule_count
);
    localparam int FW = 2 * DATA_WIDTH + 1;
    localparam int SW = $clog2(SKIP_GRANULES + 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(GRANULE_SAMPLES - 1);

    state_t state;
    logic [ADDR_WIDTH-1:0] index;
    logic [SW-1:0] skip_cnt;
    logic inflight, inflight_last, fifo_empty, pop, issue;
    logic [1:0] fifo_count;
    logic [FW-1:0] fifo_dout;

    // The index register drives the buffer directly, so the buffer samples it in the issue cycle.
    assign pcm_read_addr = index;
    assign sample_valid = !fifo_empty;
    assign pop = sample_valid && sample_ready;
    // Occupancy after this cycle's pop plus the read returning next cycle must leave room.
    assign issue = state == ST_FETCH && (fifo_count - {1'b0, pop} + {1'b0, inflight}) < 2'd2;
    assign {sample_last, sample_ch1, sample_ch0} = fifo_dout;

    pcm_skid_fifo #(.WIDTH(FW)) fifo (
        .clk(clk),
        .rst(rst),
        .push(inflight),
        .pop(pop),
        .din({inflight_last, pcm_read_data_ch1, pcm_read_data_ch0}),
        .dout(fifo_dout),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= SKIP_GRANULES > 0 ? ST_SKIP : ST_IDLE;
            index <= '0;
            skip_cnt <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
            pcm_done <= 1'b0;
            granule_count <= '0;
        end else begin
            pcm_done <= 1'b0;
            inflight <= issue;
            inflight_last <= issue && index == LAST_IDX;
            case (state)
                ST_SKIP: if (pcm_ready) begin
                    pcm_done <= 1'b1;
                    skip_cnt <= skip_cnt + 1'b1;
                    state <= ST_GUARD;
                end
                ST_IDLE: if (pcm_ready) begin
                    index <= '0;
                    state <= ST_FETCH;
                end
                ST_FETCH: if (issue) begin
                    if (index == LAST_IDX) state <= ST_DRAIN;
                    else index <= index + 1'b1;
                end
                ST_DRAIN: if (fifo_empty && !inflight) begin
                    pcm_done <= 1'b1;
                    granule_count <= granule_count + 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_GUARD;
                ST_GUARD: state <= skip_cnt == SW'(SKIP_GRANULES) ? ST_IDLE : ST_SKIP;
                default: state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_pcm_granule_reader.sv
// tb_pcm_granule_reader: randomized self-checking bench for pcm_granule_reader
module tb_pcm_granule_reader;
    localparam int N = 576;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic ready0 = 1'b0, sready0 = 1'b0, done0, valid0, last0;
    logic [9:0] addr0;
    logic [17:0] rd0_0, rd0_1, ch0_0, ch1_0;
    logic [15:0] gc0;
    logic ready1 = 1'b0, sready1 = 1'b0, done1, valid1, last1;
    logic [9:0] addr1;
    logic [17:0] rd1_0, rd1_1, ch0_1, ch1_1;
    logic [15:0] gc1;

    logic [17:0] ch1_mem [1024];
    logic [7:0] seq = 8'd0;
    int vecs = 0, errs = 0, gmodel = 0;

    // Buffer for u0: ch0 tags granule sequence and index, ch1 is random per granule.
    always @(posedge clk) begin
        rd0_0 <= {seq, addr0};
        rd0_1 <= ch1_mem[addr0];
        rd1_0 <= 18'(addr1);
        rd1_1 <= ~18'(addr1);
    end

    pcm_granule_reader u0 (
        .clk(clk), .rst(rst), .pcm_ready(ready0), .pcm_done(done0), .pcm_read_addr(addr0),
        .pcm_read_data_ch0(rd0_0), .pcm_read_data_ch1(rd0_1), .sample_valid(valid0),
        .sample_ready(sready0), .sample_ch0(ch0_0), .sample_ch1(ch1_0), .sample_last(last0),
        .granule_count(gc0)
    );

    pcm_granule_reader #(.SKIP_GRANULES(3)) u1 (
        .clk(clk), .rst(rst), .pcm_ready(ready1), .pcm_done(done1), .pcm_read_addr(addr1),
        .pcm_read_data_ch0(rd1_0), .pcm_read_data_ch1(rd1_1), .sample_valid(valid1),
        .sample_ready(sready1), .sample_ch0(ch0_1), .sample_ch1(ch1_1), .sample_last(last1),
        .granule_count(gc1)
    );

    // mode: 0 ready high, 1 pattern 1,0,0,1, 2 random, 3 stalled for 1000 cycles.
    task automatic granule(input int mode, input int hold, input int rst_at, output int acc, output int dones);
        logic [36:0] prev, cur, expv;
        logic pstall;
        int post;
        seq = seq + 8'd1;
        for (int i = 0; i < N; i++) ch1_mem[i] = 18'($urandom);
        acc = 0; dones = 0; post = 0; pstall = 1'b0; prev = '0;
        ready0 = 1'b1;
        for (int cyc = 0; cyc < 20000 && post < 8; cyc++) begin
            @(negedge clk);
            case (mode)
                0: sready0 = 1'b1;
                1: sready0 = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: sready0 = 1'($urandom);
                default: sready0 = cyc >= 1000;
            endcase
            cur = {last0, ch1_0, ch0_0};
            if (pstall) begin
                vecs++;
                if (cur !== prev) begin errs++; $display("FAIL stall_hold: got %h want %h", cur, prev); end
            end
            if (valid0 && sready0) begin
                expv = {1'(acc == N - 1), ch1_mem[10'(acc)], seq, 10'(acc)};
                vecs++;
                if (cur !== expv) begin errs++; $display("FAIL sample[%0d]: got %h want %h", acc, cur, expv); end
                acc++;
            end else if ((mode == 0 || mode == 3) && acc > 0 && acc < N && !valid0) begin
                vecs++; errs++;
                $display("FAIL gap at sample %0d: valid %b want 1", acc, valid0);
            end
            if (mode == 3 && cyc == 999) begin
                vecs++;
                if (!(valid0 === 1'b1 && addr0 === 10'd2 && ch0_0 === {seq, 10'd0})) begin
                    errs++;
                    $display("FAIL stall_state: valid %b addr %0d ch0 %h want 1 2 %h", valid0, addr0, ch0_0, {seq, 10'd0});
                end
            end
            if (dones > 0 && valid0) begin
                vecs++; errs++;
                $display("FAIL restart: valid %b after done want 0", valid0);
            end
            if (done0) begin
                dones++; gmodel++; vecs++;
                if (acc !== N || gc0 !== 16'(gmodel)) begin
                    errs++;
                    $display("FAIL done: samples %0d count %0d want %0d %0d", acc, gc0, N, gmodel);
                end
            end
            if (dones > 0) begin
                if (post >= hold) ready0 = 1'b0;
                post++;
            end
            if (rst_at >= 0 && acc == rst_at) begin
                rst = 1'b1;
                #1;
                vecs++;
                if ({done0, valid0, last0, addr0, ch0_0, ch1_0, gc0} !== '0) begin
                    errs++;
                    $display("FAIL async_reset: done %b valid %b last %b addr %0d ch0 %h ch1 %h count %0d want all 0",
                             done0, valid0, last0, addr0, ch0_0, ch1_0, gc0);
                end
                gmodel = 0;
                ready0 = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    vecs++;
                    if (done0 !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done0); end
                end
                rst = 1'b0;
                return;
            end
            pstall = valid0 && !sready0;
            prev = cur;
        end
        if (post < 8) begin
            vecs++; errs++;
            $display("FAIL timeout: samples %0d dones %0d want %0d 1", acc, dones, N);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({done0, valid0, last0, addr0, ch0_0, ch1_0, gc0} !== '0) begin
            errs++;
            $display("FAIL reset_u0: done %b valid %b last %b addr %0d ch0 %h ch1 %h count %0d want all 0",
                     done0, valid0, last0, addr0, ch0_0, ch1_0, gc0);
        end
        vecs++;
        if ({done1, valid1, addr1, gc1} !== '0) begin
            errs++;
            $display("FAIL reset_u1: done %b valid %b addr %0d count %0d want all 0", done1, valid1, addr1, gc1);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vecs++;
        if (valid0 !== 1'b0 || done1 !== 1'b0) begin
            errs++;
            $display("FAIL idle_quiet: valid0 %b done1 %b want 0 0", valid0, done1);
        end
    endtask

    task automatic test_basic();
        int acc, dones;
        granule(0, 0, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N || gc0 !== 16'd1) begin
            errs++;
            $display("FAIL basic: dones %0d samples %0d count %0d want 1 %0d 1", dones, acc, gc0, N);
        end
    endtask

    task automatic test_toggle_ready();
        int acc, dones;
        granule(1, 0, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N) begin
            errs++;
            $display("FAIL toggle: dones %0d samples %0d want 1 %0d", dones, acc, N);
        end
        for (int r = 0; r < 2; r++) begin
            granule(2, 0, -1, acc, dones);
            vecs++;
            if (dones != 1 || acc != N) begin
                errs++;
                $display("FAIL random_ready: dones %0d samples %0d want 1 %0d", dones, acc, N);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc, dones;
        granule(0, 2, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N) begin
            errs++;
            $display("FAIL hold_ready: dones %0d samples %0d want 1 %0d", dones, acc, N);
        end
        granule(0, 2, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N || gc0 !== 16'(gmodel)) begin
            errs++;
            $display("FAIL back_to_back: dones %0d samples %0d count %0d want 1 %0d %0d", dones, acc, gc0, N, gmodel);
        end
    endtask

    task automatic test_mid_reset();
        int acc, dones;
        granule(0, 0, 300, acc, dones);
        vecs++;
        if (dones != 0 || acc != 300) begin
            errs++;
            $display("FAIL mid_reset: dones %0d samples %0d want 0 300", dones, acc);
        end
        granule(0, 0, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N || gc0 !== 16'd1) begin
            errs++;
            $display("FAIL after_reset: dones %0d samples %0d count %0d want 1 %0d 1", dones, acc, gc0, N);
        end
    endtask

    task automatic test_stall();
        int acc, dones;
        granule(3, 0, -1, acc, dones);
        vecs++;
        if (dones != 1 || acc != N) begin
            errs++;
            $display("FAIL stall: dones %0d samples %0d want 1 %0d", dones, acc, N);
        end
    endtask

    task automatic test_skip();
        int acc, dones, vs;
        for (int g = 0; g < 5; g++) begin
            acc = 0; dones = 0; vs = 0;
            ready1 = 1'b1;
            for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
                @(negedge clk);
                sready1 = 1'($urandom);
                if (valid1) vs++;
                if (valid1 && sready1) begin
                    vecs++;
                    if ({last1, ch1_1, ch0_1} !== {1'(acc == N - 1), ~18'(acc), 18'(acc)}) begin
                        errs++;
                        $display("FAIL skip_sample[%0d]: got %h want %h", acc, {last1, ch1_1, ch0_1},
                                 {1'(acc == N - 1), ~18'(acc), 18'(acc)});
                    end
                    acc++;
                end
                if (done1) begin
                    dones++;
                    ready1 = 1'b0;
                end
            end
            repeat (3) @(negedge clk);
            vecs++;
            if (g < 3 ? (vs != 0 || dones != 1) : (acc != N || dones != 1)) begin
                errs++;
                $display("FAIL skip_granule %0d: valid cycles %0d samples %0d dones %0d", g, vs, acc, dones);
            end
        end
        vecs++;
        if (gc1 !== 16'd2) begin errs++; $display("FAIL skip_count: got %0d want 2", gc1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_skip();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
